// File: rtl/button_conditioner.sv
// Per-button synchronizer + debounce FSM producing level, press/release strobes and toggle bit.
// Optional auto-repeat of press_pulse while held: define BUTTON_REPEAT_EN.
module button_conditioner #(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] toggled
);

    localparam logic [1:0] S_RELEASED        = 2'd0;
    localparam logic [1:0] S_PRESS_PENDING   = 2'd1;
    localparam logic [1:0] S_PRESSED         = 2'd2;
    localparam logic [1:0] S_RELEASE_PENDING = 2'd3;

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

`ifdef BUTTON_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
`endif

    // Reject configurations the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_conditioner: invalid timing parameters");
    end

    logic [N_BUTTONS-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        logic [1:0]    state;
        logic [CW-1:0] count;
        logic          pressed_q, press_q, release_q, toggled_q;
        logic          count_done;

        assign count_done = (count == CW'(DEBOUNCE_CYCLES - 1));

`ifdef BUTTON_REPEAT_EN
        logic [RW-1:0] rpt_cnt;
        logic          rpt_first;
        logic          rpt_hit;
        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
        assign rpt_hit = rpt_first ? (rpt_cnt == RW'(REPEAT_PERIOD - 1))
                                   : (rpt_cnt == RW'(REPEAT_DELAY - 1));
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= S_RELEASED;
                count     <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                toggled_q <= 1'b0;
`ifdef BUTTON_REPEAT_EN
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    S_RELEASED: begin
                        if (sync2[i]) begin
                            state <= S_PRESS_PENDING;
                            count <= '0;
                        end
                    end
                    S_PRESS_PENDING: begin
                        if (!sync2[i]) begin
                            state <= S_RELEASED;
                            count <= '0;
                        end else if (count_done) begin
                            state     <= S_PRESSED;
                            count     <= '0;
                            pressed_q <= 1'b1;
                            press_q   <= 1'b1;
                            toggled_q <= ~toggled_q;
`ifdef BUTTON_REPEAT_EN
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b0;
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    S_PRESSED: begin
                        if (!sync2[i]) begin
                            state <= S_RELEASE_PENDING;
                            count <= '0;
                        end
`ifdef BUTTON_REPEAT_EN
                        else if (rpt_hit) begin
                            press_q   <= 1'b1;
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
`endif
                    end
                    S_RELEASE_PENDING: begin
                        // Repeat counter is frozen here so a glitch resumes where it left off.
                        if (sync2[i]) begin
                            state <= S_PRESSED;
                            count <= '0;
                        end else if (count_done) begin
                            state     <= S_RELEASED;
                            count     <= '0;
                            pressed_q <= 1'b0;
                            release_q <= 1'b1;
`ifdef BUTTON_REPEAT_EN
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b0;
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_RELEASED;
                        count <= '0;
                    end
                endcase
            end
        end

        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign toggled[i]       = toggled_q;
    end

endmodule
